// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Moore-decoded datapath selects with a ready/timeout memory handshake.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       br_cond,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       reg_we,
   output logic       instret,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD,
      MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALR,
      JALR_LINK, LUI, AUIPC, TRAP
   } state_t;

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             mem_st;
   logic             timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign mem_st  = (state_q == FETCH) || (state_q == MEMREAD) ||
                    (state_q == MEMWRITE);
   // A ready arriving in the cycle the limit is reached still completes.
   assign timeout = (TIMEOUT_CYCLES != 0) && mem_st && !mem_ready &&
                    (cnt_q == TO_LIM);

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      if (mem_st && !mem_ready) cnt_d = cnt_q + 1'b1;
      unique case (state_q)
         FETCH:     if (mem_ready) state_d = DECODE;
         DECODE: begin
            unique case (opcode)
               7'b0000011,
               7'b0100011: state_d = MEMADR;
               7'b0110011: state_d = EXECR;
               7'b0010011: state_d = EXECI;
               7'b1100011: state_d = BRANCH;
               7'b1101111: state_d = JAL;
               7'b1100111: state_d = JALR;
               7'b0110111: state_d = LUI;
               7'b0010111: state_d = AUIPC;
               default: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR:    state_d = (opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
         MEMREAD:   if (mem_ready) state_d = MEMWB;
         MEMWB:     state_d = FETCH;
         MEMWRITE:  if (mem_ready) state_d = FETCH;
         EXECR:     state_d = ALUWB;
         EXECI:     state_d = ALUWB;
         ALUWB:     state_d = FETCH;
         BRANCH:    state_d = FETCH;
         JAL:       state_d = ALUWB;
         JALR:      state_d = JALR_LINK;
         JALR_LINK: state_d = ALUWB;
         LUI:       state_d = FETCH;
         AUIPC:     state_d = ALUWB;
         TRAP:      state_d = TRAP;
      endcase
      if (timeout) begin
         state_d   = TRAP;
         bus_err_d = 1'b1;
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      reg_we     = 1'b0;
      unique case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_we      = mem_ready;
            pc_we      = mem_ready;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_we     = 1'b1;
         end
         MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         ALUWB: reg_we = 1'b1;
         BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_we     = br_cond;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_we     = 1'b1;
         end
         JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_we      = 1'b1;
         end
         JALR_LINK: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
         end
         LUI: begin
            result_src = 2'b11;
            reg_we     = 1'b1;
         end
         AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         TRAP: ;
      endcase
      instret = (state_d == FETCH) && (state_q != FETCH);
      illegal = illegal_q;
      bus_err = bus_err_q;
      state_o = state_q;
      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         adr_src    = 1'b0;
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         result_src = 2'b00;
         reg_we     = 1'b0;
         instret    = 1'b0;
         illegal    = 1'b0;
         bus_err    = 1'b0;
         state_o    = 4'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream against a path-based model.
// Expected per-cycle outputs are queued by the driver and checked by a monitor.
module tb_multicycle_ctrl;

   localparam int TO = 4;
   localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3;
   localparam int MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7;
   localparam int ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11;
   localparam int JALR_LINK = 12, LUI = 13, AUIPC = 14, TRAP = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       br_cond = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, adr_src, ir_we, pc_we;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic       reg_we, instret, illegal, bus_err;
   logic [3:0] state_o;

   multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .br_cond(br_cond),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .reg_we(reg_we), .instret(instret),
      .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int          path[$];
   int          wcnt;
   bit          ill, berr;
   logic [11:0] sel_tab [16];
   logic [20:0] expq[$];
   logic [20:0] mon_e, mon_g;
   int          nvec = 0;
   int          nerr = 0;
   logic [6:0]  legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1100011, 7'b1101111,
                               7'b1100111, 7'b0110111, 7'b0010111};

   function automatic logic [11:0] mk(input logic rq, we, adr,
                                      input logic [1:0] a, b, op, rs,
                                      input logic rw);
      return {rq, we, adr, a, b, op, rs, rw};
   endfunction

   function automatic bit is_mem(input int st);
      return st == FETCH || st == MEMREAD || st == MEMWRITE;
   endfunction

   function automatic logic [20:0] model_out();
      int          st;
      logic [11:0] s;
      logic        irw, pcw, ret;
      if (rst) return '0;
      st  = path[0];
      s   = sel_tab[st];
      irw = (st == FETCH) && mem_ready;
      pcw = irw || (st == BRANCH && br_cond) || st == JAL || st == JALR;
      ret = path.size() == 1 && st != DECODE && st != TRAP &&
            (!is_mem(st) || mem_ready);
      return {s[11:9], irw, pcw, s[8:0], ret, ill, berr, 4'(st)};
   endfunction

   function automatic void model_step();
      int st;
      if (rst) begin
         path = {FETCH, DECODE};
         wcnt = 0;
         ill  = 0;
         berr = 0;
         return;
      end
      st = path[0];
      if (st == TRAP) return;
      if (is_mem(st)) begin
         if (mem_ready) begin
            void'(path.pop_front());
            wcnt = 0;
         end else if (TO != 0 && wcnt == TO) begin
            path = {TRAP};
            berr = 1;
            wcnt = 0;
         end else wcnt++;
      end else if (st == DECODE) begin
         void'(path.pop_front());
         case (opcode)
            7'b0000011: path = {MEMADR, MEMREAD, MEMWB};
            7'b0100011: path = {MEMADR, MEMWRITE};
            7'b0110011: path = {EXECR, ALUWB};
            7'b0010011: path = {EXECI, ALUWB};
            7'b1100011: path = {BRANCH};
            7'b1101111: path = {JAL, ALUWB};
            7'b1100111: path = {JALR, JALR_LINK, ALUWB};
            7'b0110111: path = {LUI};
            7'b0010111: path = {AUIPC, ALUWB};
            default: begin
               path = {TRAP};
               ill  = 1;
            end
         endcase
      end else void'(path.pop_front());
      if (path.size() == 0) path = {FETCH, DECODE};
   endfunction

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         mon_g = {mem_req, mem_we, adr_src, ir_we, pc_we, alu_src_a,
                  alu_src_b, alu_op, result_src, reg_we, instret,
                  illegal, bus_err, state_o};
         nvec++;
         if (mon_g !== mon_e) begin
            nerr++;
            $display("FAIL vec%0d outputs got=%h exp=%h", nvec, mon_g, mon_e);
         end
      end
   end

   initial begin
      int         st, r, tgt, trap_cyc, hold, idx;
      logic [6:0] cur_op;
      sel_tab[FETCH]     = mk(1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
      sel_tab[DECODE]    = mk(0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
      sel_tab[MEMADR]    = mk(0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
      sel_tab[MEMREAD]   = mk(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      sel_tab[MEMWB]     = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
      sel_tab[MEMWRITE]  = mk(1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      sel_tab[EXECR]     = mk(0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
      sel_tab[EXECI]     = mk(0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0);
      sel_tab[ALUWB]     = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      sel_tab[BRANCH]    = mk(0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0);
      sel_tab[JAL]       = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
      sel_tab[JALR]      = mk(0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0);
      sel_tab[JALR_LINK] = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
      sel_tab[LUI]       = mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
      sel_tab[AUIPC]     = mk(0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
      sel_tab[TRAP]      = '0;
      path     = {FETCH, DECODE};
      wcnt     = 0;
      ill      = 0;
      berr     = 0;
      tgt      = 0;
      trap_cyc = 0;
      hold     = 10;
      cur_op   = 7'b0110011;
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk);
         #1;
         st  = path[0];
         rst = (c < 2) || ($urandom_range(0, 249) == 0) ||
               (st == TRAP && trap_cyc >= hold);
         if (st == TRAP) trap_cyc++;
         else begin
            trap_cyc = 0;
            hold     = $urandom_range(3, 25);
         end
         br_cond = 1'($urandom);
         if (st == FETCH) begin
            idx    = $urandom_range(0, 19);
            cur_op = (idx < 18) ? legal[idx % 9] :
                     (idx == 18) ? 7'b1111111 : 7'b0001111;
            opcode = 7'($urandom);
         end else opcode = cur_op;
         if (is_mem(st)) begin
            if (wcnt == 0) begin
               r   = $urandom_range(0, 15);
               tgt = (r < 9) ? 0 : (r < 12) ? r - 8 : (r < 15) ? TO : TO + 1;
            end
            mem_ready = (wcnt == tgt);
         end else mem_ready = 1'($urandom);
         expq.push_back(model_out());
         model_step();
      end
      repeat (2) @(posedge clk);
      #1;
      if (expq.size() != 0) begin
         nerr++;
         $display("FAIL drain pending=%0d exp=0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
